// File: rtl/mantissa_normalizer_seq.sv
// Sequential mantissa normalizer: shifts left until the hidden bit is set, the exponent hits 1, or the mantissa is zero.
// Define NORM_FAST_SHIFT_EN to add a 4-bit shift step (same results, lower latency).
module mantissa_normalizer_seq #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] in_man,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_man,
  output logic [EXP_W-1:0] out_exp,
  output logic [4:0]       out_shift,
  output logic             out_zero,
  output logic             out_uflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [MAN_W-1:0] man_reg;
  logic [EXP_W-1:0] exp_reg;
  logic [4:0]       cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      man_reg   <= '0;
      exp_reg   <= '0;
      cnt_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_man   <= '0;
      out_exp   <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            man_reg   <= in_man;
            exp_reg   <= in_exp;
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            state_reg <= SHIFT;
          end
        end

        SHIFT: begin
          // Zero is tested first so a zero mantissa never burns shift cycles.
          if (man_reg == '0) begin
            out_man   <= '0;
            out_exp   <= '0;
            out_shift <= '0;
            out_zero  <= 1'b1;
            out_uflow <= 1'b0;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (man_reg[MAN_W-1]) begin
            out_man   <= man_reg;
            out_exp   <= exp_reg;
            out_shift <= cnt_reg;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else if (exp_reg <= EXP_W'(1)) begin
            out_man   <= man_reg;
            out_exp   <= exp_reg;
            out_shift <= cnt_reg;
            out_zero  <= 1'b0;
            out_uflow <= 1'b1;
            out_valid <= 1'b1;
            state_reg <= DONE;
`ifdef NORM_FAST_SHIFT_EN
          // exp > 4 guarantees the four skipped single steps could not have hit the exponent floor.
          end else if ((man_reg[MAN_W-1 -: 4] == 4'd0) && (exp_reg > EXP_W'(4))) begin
            man_reg <= {man_reg[MAN_W-5:0], 4'b0000};
            exp_reg <= exp_reg - EXP_W'(4);
            cnt_reg <= cnt_reg + 5'd4;
`endif
          end else begin
            man_reg <= {man_reg[MAN_W-2:0], 1'b0};
            exp_reg <= exp_reg - EXP_W'(1);
            cnt_reg <= cnt_reg + 5'd1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_normalizer_seq.sv
// Bench for mantissa_normalizer_seq: leading-zero reference model plus directed literal vectors.
module tb_mantissa_normalizer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_man;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_man;
  logic [7:0]  out_exp;
  logic [4:0]  out_shift;
  logic        out_zero;
  logic        out_uflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [23:0] man;
    logic [7:0]  exp;
    logic [4:0]  sh;
    logic        z;
    logic        u;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];

  mantissa_normalizer_seq #(.MAN_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_man(in_man), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_man(out_man), .out_exp(out_exp),
    .out_shift(out_shift), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  // Reference: shift = min(leading zeros, exp-1); latency = shift steps taken + 1.
  function automatic exp_t model(input logic [23:0] m, input logic [7:0] e, input int acc);
    exp_t r;
    int lz, lim, s;
    int l, ee, steps;
    r.acc = acc;
    if (m == 24'd0) begin
      r.man = '0; r.exp = '0; r.sh = '0; r.z = 1'b1; r.u = 1'b0; r.lat = 1;
      return r;
    end
    lz = 0;
    for (int i = 23; i >= 0; i--) begin
      if (m[i]) break;
      lz++;
    end
    lim = (e > 8'd1) ? int'(e) - 1 : 0;
    s = (lz < lim) ? lz : lim;
    r.man = m << s;
    r.exp = e - 8'(s);
    r.sh  = 5'(s);
    r.z   = 1'b0;
    r.u   = (lz > lim);
`ifdef NORM_FAST_SHIFT_EN
    l = lz; ee = int'(e); steps = 0;
    while (l >= 4 && ee > 4) begin
      l -= 4; ee -= 4; steps++;
    end
    steps += (l < ee - 1) ? l : ((ee > 1) ? ee - 1 : 0);
    r.lat = steps + 1;
`else
    l = 0; ee = 0; steps = 0;
    r.lat = s + 1;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Accept monitor: enqueue the model's answer for every operand the DUT takes.
  initial forever begin
    @(posedge clk);
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back(model(in_man, in_exp, cyc));
    cyc++;
  end

  // Compare process: every presented result must match the model and keep its timing.
  initial begin : compare
    bit seen;
    int meas;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=%h required=none", out_man);
        end else begin
          chk("model_result", {out_man, out_exp, out_shift, out_zero, out_uflow},
              {q[0].man, q[0].exp, q[0].sh, q[0].z, q[0].u});
          chk("ready_in_done", in_ready, 1'b0);
          if (!seen) begin
            meas = cyc - q[0].acc - 1;
            chk("model_latency", 64'(meas), 64'(q[0].lat));
            seen = 1'b1;
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [23:0] m, input logic [7:0] e);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("ready_timeout", in_ready, 1'b1);
    in_man = m; in_exp = e; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_lit(input logic [23:0] m, input logic [7:0] e,
                         input logic [23:0] xm, input logic [7:0] xe, input logic [4:0] xs,
                         input logic xz, input logic xu, input int xl);
    int n;
    send(m, e);
    wait_valid(n);
    chk("lit_latency", 64'(n), 64'(xl));
    chk("lit_result", {out_man, out_exp, out_shift, out_zero, out_uflow}, {xm, xe, xs, xz, xu});
    $display("txn man=%h exp=%h -> man=%h exp=%h shift=%0d zero=%b uflow=%b lat=%0d",
             m, e, out_man, out_exp, out_shift, out_zero, out_uflow, n);
    handshake();
  endtask

  initial begin
    int n;
    logic [23:0] rm;
    logic [7:0]  re;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_man = '0; in_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {out_valid, out_man, out_exp, out_shift, out_zero, out_uflow}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1'b1);

    run_lit(24'h800000, 8'h80, 24'h800000, 8'h80, 5'd0, 1'b0, 1'b0, 1);
`ifdef NORM_FAST_SHIFT_EN
    run_lit(24'h000001, 8'h80, 24'h800000, 8'h69, 5'd23, 1'b0, 1'b0, 9);
    run_lit(24'h0000F0, 8'h20, 24'hF00000, 8'h10, 5'd16, 1'b0, 1'b0, 5);
    run_lit(24'h000001, 8'h05, 24'h000010, 8'h01, 5'd4, 1'b0, 1'b1, 2);
`else
    run_lit(24'h000001, 8'h80, 24'h800000, 8'h69, 5'd23, 1'b0, 1'b0, 24);
    run_lit(24'h0000F0, 8'h20, 24'hF00000, 8'h10, 5'd16, 1'b0, 1'b0, 17);
    run_lit(24'h000001, 8'h05, 24'h000010, 8'h01, 5'd4, 1'b0, 1'b1, 5);
`endif
    run_lit(24'h000000, 8'h55, 24'h000000, 8'h00, 5'd0, 1'b1, 1'b0, 1);
    run_lit(24'h000100, 8'h03, 24'h000400, 8'h01, 5'd2, 1'b0, 1'b1, 3);
    run_lit(24'h000010, 8'h00, 24'h000010, 8'h00, 5'd0, 1'b0, 1'b1, 1);

    // Back-pressure: a second operand waits until the held result is taken.
    send(24'h000100, 8'h03);
    wait_valid(n);
    in_man = 24'h400000; in_exp = 8'h10; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_out", {out_valid, out_man, out_exp, out_shift, out_zero, out_uflow},
          {1'b1, 24'h000400, 8'h01, 5'd2, 1'b0, 1'b1});
    end
    handshake();
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    chk("second_latency", 64'(n), 64'd2);
    chk("second_result", {out_man, out_exp, out_shift, out_zero, out_uflow},
        {24'h800000, 8'h0F, 5'd1, 1'b0, 1'b0});
    $display("txn man=400000 exp=10 after hold -> man=%h exp=%h shift=%0d lat=%0d",
             out_man, out_exp, out_shift, n);
    handshake();

    // Abort mid-shift: reset clears outputs at once and the operand is never presented.
    send(24'h000001, 8'h80);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("abort_out", {out_valid, out_man, out_exp, out_shift, out_zero, out_uflow}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", in_ready, 1'b1);
    $display("txn man=000001 exp=80 aborted by reset");
    run_lit(24'h400000, 8'h10, 24'h800000, 8'h0F, 5'd1, 1'b0, 1'b0, 2);

    for (int i = 0; i < 8; i++) begin
      rm = 24'($urandom_range(0, 24'hFFFFFF) >> $urandom_range(0, 23));
      re = 8'($urandom_range(0, 255));
      send(rm, re);
      wait_valid(n);
      chk("rand_valid", out_valid, 1'b1);
      $display("txn man=%h exp=%h -> man=%h exp=%h shift=%0d zero=%b uflow=%b lat=%0d",
               rm, re, out_man, out_exp, out_shift, out_zero, out_uflow, n);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 handshake();
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mantissa_normalizer_seq.md
MANTISSA_NORMALIZER_SEQ -- requirements
Module: mantissa_normalizer_seq

Interface
REQ-001 SHALL provide parameter MAN_W, default 24: mantissa width including hidden bit.
REQ-002 SHALL provide parameter EXP_W, default 8: biased exponent width.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  source presents an operand.
REQ-006 SHALL provide port in_ready  output  1  block can accept an operand.
REQ-007 SHALL provide port in_man  input  MAN_W  unnormalized mantissa, MSB = hidden-bit position.
REQ-008 SHALL provide port in_exp  input  EXP_W  biased exponent of in_man.
REQ-009 SHALL provide port out_valid  output  1  normalized result available.
REQ-010 SHALL provide port out_ready  input  1  sink accepts the result.
REQ-011 SHALL provide port out_man  output  MAN_W  normalized mantissa.
REQ-012 SHALL provide port out_exp  output  EXP_W  adjusted exponent.
REQ-013 SHALL provide port out_shift  output  5  total left-shift count applied.
REQ-014 SHALL provide port out_zero  output  1  input mantissa was zero.
REQ-015 SHALL provide port out_uflow  output  1  shifting stopped at exponent 1 before MSB set (denormal result).

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 In IDLE, in_valid=1 at an edge SHALL capture in_man/in_exp, clear shift count, and enter SHIFT.
REQ-018 In SHIFT, if man==0: SHALL go to DONE with out_zero=1, out_exp=0, out_man=0, out_shift=0.
REQ-019 In SHIFT, if man[MAN_W-1]==1: SHALL go to DONE unchanged.
REQ-020 In SHIFT, if MSB==0 and exp<=1: SHALL go to DONE with out_uflow=1, mantissa/exponent unchanged.
REQ-021 Otherwise, in SHIFT: SHALL shift man left 1 (zero fill), decrement exp by 1, increment shift count by 1, remain in SHIFT.
REQ-022 Latency: for k shift steps, out_valid SHALL rise k+1 cycles after the accepting edge.
REQ-023 In DONE, all out_* SHALL hold stable until out_valid && out_ready at an edge, then return to IDLE.
REQ-024 in_valid while not in IDLE SHALL be ignored; no operand is dropped or overwritten.
REQ-025 Exponent SHALL never go below 1 by shifting; out_shift SHALL never exceed MAN_W-1.
REQ-026 Results SHALL be registered; no combinational path from in_* to out_*.

Reset
REQ-027 rst=1 SHALL immediately force IDLE and clear out_man, out_exp, out_shift, out_zero, out_uflow, out_valid to 0.
REQ-028 in_ready SHALL read 1 on the first cycle after rst deasserts.
REQ-029 rst asserted mid-SHIFT or mid-DONE SHALL abort the operation; no result is ever presented for it.

Configuration
REQ-030 Macro NORM_FAST_SHIFT_EN SHALL control a 4-bit fast-shift step.
REQ-031 With NORM_FAST_SHIFT_EN defined: in SHIFT, if top 4 mantissa bits are 0 and exp>4, SHALL shift left 4, exp-4, count+4 in one cycle; otherwise REQ-018..REQ-021 apply.
REQ-032 Without NORM_FAST_SHIFT_EN: only the 1-bit step exists; results are bit-identical in both builds, only latency differs.

Verification
REQ-033 in_man=0x800000, in_exp=0x80 -> out_valid 1 cycle after accept; out_man=0x800000, out_exp=0x80, out_shift=0, flags 0.
REQ-034 in_man=0x000001, in_exp=0x80 -> out_man=0x800000, out_exp=0x69, out_shift=23; out_valid after 24 cycles (9 cycles with NORM_FAST_SHIFT_EN).
REQ-035 in_man=0x000000, in_exp=0x55 -> out_zero=1, out_man=0, out_exp=0, out_shift=0, out_valid after 1 cycle.
REQ-036 in_man=0x000100, in_exp=0x03 -> out_man=0x000400, out_exp=0x01, out_shift=2, out_uflow=1, out_valid after 3 cycles.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data -> outputs stable, in_ready=0, second operand accepted only after handshake.
REQ-038 Assert rst during SHIFT of in_man=0x000001 -> outputs 0 immediately, in_ready=1 after release, next operand 0x400000/0x10 yields 0x800000/0x0F, shift 1.
